// File: rtl/tpumac_pkg.sv
// tpumac_pkg: shared defaults, parameter legality helpers and saturation limits for the TPU MAC cell.
package tpumac_pkg;

  localparam int DEF_BITS_AB = 8;
  localparam int DEF_BITS_C  = 16;
  localparam int DEF_PIPE    = 1;

  function automatic bit widths_ok(input int bits_ab, input int bits_c);
    return bits_c >= 2 * bits_ab;
  endfunction

  function automatic bit pipe_ok(input int pipe);
    return (pipe == 0) || (pipe == 1);
  endfunction

  function automatic longint sat_max(input int bits);
    return (longint'(1) <<< (bits - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int bits);
    return -(longint'(1) <<< (bits - 1));
  endfunction

endpackage

// File: rtl/tpumac_sat_add.sv
// tpumac_sat_add: one-bit-wider accumulate add with overflow detect.
// Define TPUMAC_SAT_EN to clamp overflowing results; otherwise they wrap.
module tpumac_sat_add
  import tpumac_pkg::*;
#(
  parameter int BITS_C = DEF_BITS_C
) (
  input  logic signed [BITS_C-1:0] acc,
  input  logic signed [BITS_C-1:0] addend,
  output logic signed [BITS_C-1:0] sum,
  output logic                     ovf
);

  logic [BITS_C:0] wide;

  assign wide = {acc[BITS_C-1], acc} + {addend[BITS_C-1], addend};
  // Top two bits disagree exactly when the true sum leaves the BITS_C signed range.
  assign ovf  = wide[BITS_C] ^ wide[BITS_C-1];

`ifdef TPUMAC_SAT_EN
  localparam logic signed [BITS_C-1:0] MAX_V = BITS_C'(sat_max(BITS_C));
  localparam logic signed [BITS_C-1:0] MIN_V = BITS_C'(sat_min(BITS_C));

  always_comb begin
    sum = wide[BITS_C-1:0];
    if (ovf) sum = wide[BITS_C] ? MIN_V : MAX_V;
  end
`else
  assign sum = wide[BITS_C-1:0];
`endif

endmodule

// File: rtl/tpumac_pipe.sv
// tpumac_pipe: systolic MAC cell with optional product register stage (PIPE) and sticky overflow.
// Macro TPUMAC_SAT_EN selects saturating instead of wrapping accumulation.
module tpumac_pipe
  import tpumac_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C,
  parameter int PIPE    = DEF_PIPE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic                      clr,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout,
  output logic                      busy,
  output logic                      ovf
);

  if (!widths_ok(BITS_AB, BITS_C)) begin : g_bad_widths
    $error("tpumac_pipe: BITS_C must be at least 2*BITS_AB");
  end
  if (!pipe_ok(PIPE)) begin : g_bad_pipe
    $error("tpumac_pipe: PIPE must be 0 or 1");
  end

  logic signed [2*BITS_AB-1:0] prod_full;
  logic signed [BITS_C-1:0]    prod_ext;
  logic signed [BITS_C-1:0]    addend;
  logic signed [BITS_C-1:0]    sum;
  logic signed [BITS_C-1:0]    acc;
  logic                        do_add;
  logic                        add_ovf;
  logic                        pv;

  assign prod_full = Ain * Bin;
  assign prod_ext  = BITS_C'(prod_full);

  if (PIPE == 1) begin : g_pipe
    logic signed [BITS_C-1:0] prod_reg;

    // clr kills a same-edge capture; WrEn only discards the older product.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_reg <= '0;
        pv       <= 1'b0;
      end else begin
        if (en) prod_reg <= prod_ext;
        pv <= en & ~clr;
      end
    end

    assign addend = prod_reg;
    assign do_add = pv;
  end else begin : g_comb
    assign pv     = 1'b0;
    assign addend = prod_ext;
    assign do_add = en;
  end

  tpumac_sat_add #(
    .BITS_C (BITS_C)
  ) u_sat_add (
    .acc    (acc),
    .addend (addend),
    .sum    (sum),
    .ovf    (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Aout <= '0;
      Bout <= '0;
      acc  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (en) begin
        Aout <= Ain;
        Bout <= Bin;
      end
      if (clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (WrEn) begin
        acc <= Cin;
        ovf <= 1'b0;
      end else if (do_add) begin
        acc <= sum;
        ovf <= ovf | add_ovf;
      end
    end
  end

  assign Cout = acc;
  assign busy = pv;

endmodule

// File: tb/tb_tpumac_pipe.sv
// tb_tpumac_pipe: checks PIPE=1 and PIPE=0 instances against a queue-based reference model.
module tb_tpumac_pipe;

  logic clk = 1'b0;
  logic rst_n, en, WrEn, clr;
  logic signed [7:0]  Ain, Bin;
  logic signed [15:0] Cin;
  logic signed [7:0]  a1, b1, a0, b0;
  logic signed [15:0] c1, c0;
  logic busy1, ovf1, busy0, ovf0;

  int total = 0;
  int bad   = 0;

  int m_acc1, m_acc0, m_aout, m_bout;
  bit m_ovf1, m_ovf0;
  int pend[$];

`ifdef TPUMAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .PIPE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .clr(clr),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(a1), .Bout(b1), .Cout(c1), .busy(busy1), .ovf(ovf1)
  );

  tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .PIPE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .clr(clr),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(a0), .Bout(b0), .Cout(c0), .busy(busy0), .ovf(ovf0)
  );

  always #5 clk = ~clk;

  function automatic void acc_add(inout int acc, inout bit ov, input int p);
    int s;
    s = acc + p;
    if (s > 32767 || s < -32768) begin
      ov = 1'b1;
      if (SAT) s = (s > 0) ? 32767 : -32768;
      else     s = ((s + 32768) & 65535) - 32768;
    end
    acc = s;
  endfunction

  function automatic void model_reset();
    m_acc1 = 0; m_acc0 = 0; m_ovf1 = 0; m_ovf0 = 0;
    m_aout = 0; m_bout = 0;
    pend.delete();
  endfunction

  // Applies the architectural rules for one rising edge to the reference state.
  function automatic void model_edge();
    int p;
    p = int'(Ain) * int'(Bin);
    if (en) begin m_aout = int'(Ain); m_bout = int'(Bin); end
    if (clr) begin
      m_acc1 = 0; m_ovf1 = 0; pend.delete();
      m_acc0 = 0; m_ovf0 = 0;
    end else if (WrEn) begin
      m_acc1 = int'(Cin); m_ovf1 = 0; pend.delete();
      if (en) pend.push_back(p);
      m_acc0 = int'(Cin); m_ovf0 = 0;
    end else begin
      if (pend.size() > 0) acc_add(m_acc1, m_ovf1, pend.pop_front());
      if (en) pend.push_back(p);
      if (en) acc_add(m_acc0, m_ovf0, p);
    end
  endfunction

  task automatic step(input bit e, input bit w, input bit c, input int av, input int bv, input int cv);
    en = e; WrEn = w; clr = c;
    Ain = 8'(av); Bin = 8'(bv); Cin = 16'(cv);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; WrEn = 1'b0; clr = 1'b0; Ain = 8'sd5; Bin = 8'sd6; Cin = 16'sd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (c1 !== 16'sd0 || c0 !== 16'sd0) begin bad++; $display("FAIL reset_cout: got %0d/%0d want 0", c1, c0); end
    total++; if (a1 !== 8'sd0 || b1 !== 8'sd0 || a0 !== 8'sd0 || b0 !== 8'sd0) begin bad++; $display("FAIL reset_ab: got %0d %0d %0d %0d want 0", a1, b1, a0, b0); end
    total++; if (busy1 !== 1'b0 || busy0 !== 1'b0 || ovf1 !== 1'b0 || ovf0 !== 1'b0) begin bad++; $display("FAIL reset_flags: got busy %b%b ovf %b%b want 0", busy1, busy0, ovf1, ovf0); end
    en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    int av[4] = '{3, -2, 7, 0};
    int bv[4] = '{4, 5, 7, 0};
    int e1[4] = '{0, 12, 2, 51};
    int e0[4] = '{12, 2, 51, 51};
    bit eb[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(i < 3, 1'b0, 1'b0, av[i], bv[i], 0);
      total++; if (c1 !== 16'(e1[i])) begin bad++; $display("FAIL seq_pipe1_cout[%0d]: got %0d want %0d", i, c1, e1[i]); end
      total++; if (c0 !== 16'(e0[i])) begin bad++; $display("FAIL seq_pipe0_cout[%0d]: got %0d want %0d", i, c0, e0[i]); end
      total++; if (busy1 !== eb[i] || busy0 !== 1'b0) begin bad++; $display("FAIL seq_busy[%0d]: got %b/%b want %b/0", i, busy1, busy0, eb[i]); end
    end
    total++; if (a1 !== 8'sd7 || b0 !== 8'sd7) begin bad++; $display("FAIL seq_hold_ab: got %0d %0d want 7 7", a1, b0); end
  endtask

  task automatic test_overflow();
    int want;
    want = SAT ? 32767 : -32676;
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0, 32760);
    step(1'b1, 1'b0, 1'b0, 10, 10, 0);
    total++; if (c0 !== 16'(want) || ovf0 !== 1'b1) begin bad++; $display("FAIL ovf_pipe0: got %0d ovf %b want %0d ovf 1", c0, ovf0, want); end
    total++; if (c1 !== 16'sd32760 || ovf1 !== 1'b0) begin bad++; $display("FAIL ovf_pipe1_pending: got %0d ovf %b want 32760 ovf 0", c1, ovf1); end
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    total++; if (c1 !== 16'(want) || ovf1 !== 1'b1) begin bad++; $display("FAIL ovf_pipe1: got %0d ovf %b want %0d ovf 1", c1, ovf1, want); end
    total++; if (ovf0 !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf0); end
  endtask

  task automatic test_wren_discard();
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 5, 5, 0);
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL discard_busy_before: got %b want 1", busy1); end
    step(1'b0, 1'b1, 1'b0, 0, 0, 100);
    total++; if (c1 !== 16'sd100 || busy1 !== 1'b0) begin bad++; $display("FAIL discard_load: got %0d busy %b want 100 busy 0", c1, busy1); end
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    total++; if (c1 !== 16'sd100) begin bad++; $display("FAIL discard_after: got %0d want 100", c1); end
  endtask

  task automatic test_clr_wren();
    step(1'b1, 1'b1, 1'b0, 9, -3, 50);
    total++; if (c0 !== 16'sd50 || c1 !== 16'sd50 || busy1 !== 1'b1 || a0 !== 8'sd9) begin bad++; $display("FAIL load_with_en: got %0d %0d busy %b a %0d want 50 50 busy 1 a 9", c0, c1, busy1, a0); end
    step(1'b0, 1'b1, 1'b1, 1, 1, 77);
    total++; if (c0 !== 16'sd0 || c1 !== 16'sd0 || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin bad++; $display("FAIL clr_prio: got %0d %0d ovf %b%b want 0 0 ovf 00", c0, c1, ovf0, ovf1); end
    total++; if (a1 !== 8'sd9 || b1 !== -8'sd3 || busy1 !== 1'b0) begin bad++; $display("FAIL clr_ab: got %0d %0d busy %b want 9 -3 busy 0", a1, b1, busy1); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 1'b0, 11, 3, 40);
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL arst_pre_busy: got %b want 1", busy1); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (c1 !== 16'sd0 || c0 !== 16'sd0 || a1 !== 8'sd0 || b0 !== 8'sd0 || busy1 !== 1'b0) begin bad++; $display("FAIL arst_now: got %0d %0d %0d %0d busy %b want 0", c1, c0, a1, b0, busy1); end
    en = 1'b0; WrEn = 1'b0;
    #1 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    total++; if (c1 !== 16'sd0 || busy1 !== 1'b0 || c0 !== 16'sd0) begin bad++; $display("FAIL arst_after: got %0d busy %b %0d want 0", c1, busy1, c0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 65535)) - 32768);
      total++; if (c1 !== 16'(m_acc1) || ovf1 !== m_ovf1 || busy1 !== (pend.size() > 0)) begin bad++; $display("FAIL rand_pipe1[%0d]: got %0d ovf %b busy %b want %0d ovf %b busy %b", i, c1, ovf1, busy1, m_acc1, m_ovf1, pend.size() > 0); end
      total++; if (c0 !== 16'(m_acc0) || ovf0 !== m_ovf0 || busy0 !== 1'b0) begin bad++; $display("FAIL rand_pipe0[%0d]: got %0d ovf %b busy %b want %0d ovf %b busy 0", i, c0, ovf0, busy0, m_acc0, m_ovf0); end
      total++; if (a1 !== 8'(m_aout) || b1 !== 8'(m_bout) || a0 !== 8'(m_aout) || b0 !== 8'(m_bout)) begin bad++; $display("FAIL rand_ab[%0d]: got %0d %0d want %0d %0d", i, a1, b1, m_aout, m_bout); end
    end
  endtask

  initial begin
    test_reset();
    #1;
    test_sequence();
    test_overflow();
    test_wren_discard();
    test_clr_wren();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
